// File: rtl/ring_counter_param_if.sv
// Control/status bundle for ring_counter_param.
// The counter side uses the slave modport; the driving logic uses master.
interface ring_counter_param_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             mode;
  logic             dir;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic             wrap;
  logic             illegal;

  modport master (
    output en, mode, dir, load, load_val,
    input  q, wrap, illegal
  );

  modport slave (
    input  en, mode, dir, load, load_val,
    output q, wrap, illegal
  );
endinterface

// File: rtl/ring_counter_param.sv
// Parametrised ring / Johnson counter with run-time mode and direction,
// count enable, parallel load, self-correction of illegal states and
// registered wrap / illegal flags.
module ring_counter_param #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned INIT_POS = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  ring_counter_param_if.slave  bus
);

  typedef enum logic [1:0] {
    SH_RING_L = 2'b00,
    SH_RING_R = 2'b01,
    SH_JOHN_L = 2'b10,
    SH_JOHN_R = 2'b11
  } shift_e;

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic             r_illegal;

  logic [WIDTH-1:0] w_seed;
  logic [WIDTH-1:0] w_next;
  logic             w_ring_legal;
  logic             w_john_legal;
  logic             w_legal;
  shift_e           w_shift;

  // Seed follows the live mode input: one-hot at INIT_POS for ring, zero for Johnson
  always_comb begin
    w_seed = '0;
    if (!bus.mode) begin
      w_seed[INIT_POS] = 1'b1;
    end
  end

  // Legality of the current state against the current mode
  always_comb begin
    w_ring_legal = ($countones(r_q) == 1);
    w_john_legal = ($countones(r_q[WIDTH-1:1] ^ r_q[WIDTH-2:0]) <= 1);
    w_legal      = bus.mode ? w_john_legal : w_ring_legal;
  end

  // Next state for an enabled shift of a legal state
  always_comb begin
    w_shift = shift_e'({bus.mode, bus.dir});
    w_next  = r_q;
    unique case (w_shift)
      SH_RING_L: w_next = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
      SH_RING_R: w_next = {r_q[0], r_q[WIDTH-1:1]};
      SH_JOHN_L: w_next = {r_q[WIDTH-2:0], ~r_q[WIDTH-1]};
      SH_JOHN_R: w_next = {~r_q[0], r_q[WIDTH-1:1]};
      default:   w_next = r_q;
    endcase
  end

  // State and flag registers, priority rst > load > en > hold
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q       <= w_seed;
      r_wrap    <= 1'b0;
      r_illegal <= 1'b0;
    end else if (bus.load) begin
      r_q       <= bus.load_val;
      r_wrap    <= 1'b0;
      r_illegal <= 1'b0;
    end else if (bus.en) begin
      if (w_legal) begin
        r_q       <= w_next;
        r_wrap    <= (w_next == w_seed);
        r_illegal <= 1'b0;
      end else begin
        r_q       <= w_seed;
        r_wrap    <= 1'b0;
        r_illegal <= 1'b1;
      end
    end else begin
      r_wrap    <= 1'b0;
      r_illegal <= 1'b0;
    end
  end

  assign bus.q       = r_q;
  assign bus.wrap    = r_wrap;
  assign bus.illegal = r_illegal;

endmodule

// File: tb/tb_ring_counter_param.sv
// Self-checking bench: a 4-bit (INIT_POS=0) and an 8-bit (INIT_POS=3)
// counter driven with identical controls and compared every cycle with a
// position/index based reference model, plus directed sequence checks.
module tb_ring_counter_param;

  logic clk;
  logic rst;
  int unsigned n_tests;
  int unsigned n_fail;

  ring_counter_param_if #(.WIDTH(4)) b4 ();
  ring_counter_param_if #(.WIDTH(8)) b8 ();

  ring_counter_param #(.WIDTH(4), .INIT_POS(0)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (b4)
  );

  ring_counter_param #(.WIDTH(8), .INIT_POS(3)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (b8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] m4_q, m8_q;
  logic        m4_w, m4_i, m8_w, m8_i;
  int unsigned wraps4, wraps8;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] seed_of(input int w, input int ip, input logic m);
    logic [15:0] s;
    s = m ? 16'h0 : (16'h1 << ip);
    return s;
  endfunction

  // Johnson state number k (0..2w-1): k ones filling from the LSB, then
  // zeros filling from the LSB once all ones.
  function automatic logic [15:0] jstate(input int w, input int k);
    logic [15:0] mask;
    mask = (16'h1 << w) - 16'h1;
    if (k <= w) return (16'h1 << k) - 16'h1;
    return mask & ~((16'h1 << (k - w)) - 16'h1);
  endfunction

  function automatic int jindex(input int w, input logic [15:0] v);
    for (int k = 0; k < 2 * w; k++) begin
      if (jstate(w, k) == v) return k;
    end
    return -1;
  endfunction

  function automatic void model(input int w, input int ip,
                                input logic r, input logic ld, input logic e,
                                input logic m, input logic d,
                                input logic [15:0] lv,
                                inout logic [15:0] q,
                                output logic wr, output logic il);
    logic [15:0] s;
    logic [15:0] mask;
    int p;
    int k;
    s    = seed_of(w, ip, m);
    mask = (16'h1 << w) - 16'h1;
    wr   = 1'b0;
    il   = 1'b0;
    if (r) begin
      q = s;
    end else if (ld) begin
      q = lv & mask;
    end else if (e) begin
      if (!m) begin
        if ($countones(q) == 1) begin
          p = 0;
          for (int b = 0; b < w; b++) if (q[b]) p = b;
          p  = d ? (p + w - 1) % w : (p + 1) % w;
          q  = 16'h1 << p;
          wr = (q == s);
        end else begin
          q  = s;
          il = 1'b1;
        end
      end else begin
        k = jindex(w, q);
        if (k >= 0) begin
          k  = d ? (k + 2 * w - 1) % (2 * w) : (k + 1) % (2 * w);
          q  = jstate(w, k);
          wr = (q == s);
        end else begin
          q  = s;
          il = 1'b1;
        end
      end
    end
  endfunction

  task automatic step(input logic r, input logic ld, input logic e,
                      input logic m, input logic d, input logic [15:0] lv);
    rst         = r;
    b4.load     = ld;  b8.load     = ld;
    b4.en       = e;   b8.en       = e;
    b4.mode     = m;   b8.mode     = m;
    b4.dir      = d;   b8.dir      = d;
    b4.load_val = lv[3:0];
    b8.load_val = lv[7:0];
    @(posedge clk);
    #1;
    model(4, 0, r, ld, e, m, d, lv, m4_q, m4_w, m4_i);
    model(8, 3, r, ld, e, m, d, lv, m8_q, m8_w, m8_i);
    check("q4",   32'(b4.q),       32'(m4_q[3:0]));
    check("wrap4", 32'(b4.wrap),   32'(m4_w));
    check("ill4", 32'(b4.illegal), 32'(m4_i));
    check("q8",   32'(b8.q),       32'(m8_q[7:0]));
    check("wrap8", 32'(b8.wrap),   32'(m8_w));
    check("ill8", 32'(b8.illegal), 32'(m8_i));
    check("excl4", 32'(b4.wrap & b4.illegal), 32'(0));
    if (b4.wrap) wraps4++;
    if (b8.wrap) wraps8++;
  endtask

  logic [3:0] ring_l [4];
  logic [3:0] ring_r [4];
  logic [3:0] john_l [8];
  logic [3:0] held;
  logic       rm, rd;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m4_q = '0; m8_q = '0;
    ring_l = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    ring_r = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    john_l = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};

    // Ring reset and count left; w8 period 8 seen as one wrap over 8 shifts
    step(1, 0, 0, 0, 0, 16'h0);
    step(1, 0, 0, 0, 0, 16'h0);
    check("rst_q4", 32'(b4.q), 32'h1);
    check("rst_q8", 32'(b8.q), 32'h08);
    check("rst_flags", 32'({b4.wrap, b4.illegal}), 32'h0);
    wraps4 = 0; wraps8 = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, 0, 0, 16'h0);
      check("ring_l_q", 32'(b4.q), 32'(ring_l[i % 4]));
      check("ring_l_wrap", 32'(b4.wrap), 32'((i % 4) == 3));
    end
    check("ring_wraps4", wraps4, 2);
    check("ring_wraps8", wraps8, 1);

    // Ring right, then reverse mid-run
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 0, 1, 16'h0);
      check("ring_r_q", 32'(b4.q), 32'(ring_r[i]));
      check("ring_r_wrap", 32'(b4.wrap), 32'(i == 3));
    end
    step(0, 0, 1, 0, 1, 16'h0);
    step(0, 0, 1, 0, 1, 16'h0);
    step(0, 0, 1, 0, 0, 16'h0);
    check("dir_flip_q", 32'(b4.q), 32'b1000);
    check("dir_flip_ill", 32'(b4.illegal), 32'h0);

    // Johnson from reset; w8 period 16
    step(1, 0, 0, 1, 0, 16'h0);
    check("john_rst", 32'(b4.q), 32'h0);
    wraps4 = 0; wraps8 = 0;
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 1, 1, 0, 16'h0);
      check("john_q", 32'(b4.q), 32'(john_l[i % 8]));
    end
    check("john_wraps4", wraps4, 2);
    check("john_wraps8", wraps8, 1);

    // Illegal correction, ring then Johnson
    step(0, 1, 0, 0, 0, 16'h66);
    check("load_ill_q", 32'(b4.q), 32'b0110);
    step(0, 0, 1, 0, 0, 16'h0);
    check("ring_fix_q", 32'(b4.q), 32'b0001);
    check("ring_fix_ill", 32'(b4.illegal), 32'h1);
    check("ring_fix_wrap", 32'(b4.wrap), 32'h0);
    step(0, 0, 1, 0, 0, 16'h0);
    check("ring_fix_pulse", 32'(b4.illegal), 32'h0);
    step(0, 1, 0, 1, 0, 16'h22);
    step(0, 0, 1, 1, 0, 16'h0);
    check("john_fix_q", 32'(b4.q), 32'h0);
    check("john_fix_ill", 32'(b4.illegal), 32'h1);

    // Hold, load over en, rst over load
    step(0, 1, 0, 0, 0, 16'h44);
    held = b4.q;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0, 16'h0);
      check("hold_q", 32'(b4.q), 32'(held));
      check("hold_flags", 32'({b4.wrap, b4.illegal}), 32'h0);
    end
    step(0, 1, 1, 0, 0, 16'h99);
    check("load_en_q", 32'(b4.q), 32'b1001);
    step(0, 1, 0, 0, 0, 16'h44);
    step(1, 1, 1, 0, 0, 16'hff);
    check("rst_load_q", 32'(b4.q), 32'b0001);

    // Mode switch at 0100 into Johnson
    step(0, 1, 0, 0, 0, 16'h44);
    step(0, 0, 1, 1, 0, 16'h0);
    check("mode_sw_q", 32'(b4.q), 32'h0);
    check("mode_sw_ill", 32'(b4.illegal), 32'h1);

    // Randomised traffic against the model
    rm = 1'b0;
    rd = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(19, 0) == 0) rm = ~rm;
      if ($urandom_range(7, 0) == 0)  rd = ~rd;
      step(($urandom_range(59, 0) == 0), ($urandom_range(11, 0) == 0),
           ($urandom_range(3, 0) != 0), rm, rd, 16'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ring_counter_param.md
Name:
ring_counter_param

Overview:
- Parametrised successor to the fixed 4-bit ring counter.
- Generalises to WIDTH bits and adds:
  - run-time ring / Johnson (twisted-ring) mode
  - shift direction
  - count enable
  - parallel load
  - self-correction of illegal states
  - registered wrap and illegal-state flags
- Used as a one-hot / thermometer sequencer for phase selection and round-robin timing.

Parameters:
- WIDTH, 4, counter width in bits; legal range 2 or more.
- INIT_POS, 0, bit index of the hot bit in the ring-mode seed; legal range 0 to WIDTH-1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- en  input  1  count enable; shift occurs on an edge with en=1
- mode  input  1  0 = ring (one-hot), 1 = Johnson
- dir  input  1  0 = shift toward MSB, 1 = shift toward LSB
- load  input  1  parallel load strobe
- load_val  input  WIDTH  value loaded when load=1
- q  output  WIDTH  counter state
- wrap  output  1  registered pulse; q has just returned to the seed by a shift
- illegal  output  1  registered pulse; an illegal state was corrected on this edge

Behaviour:
- One clock; reset is synchronous and active-high: rst is sampled only on rising clk, with no asynchronous path.
- Seed definition:
  - ring: one-hot with bit INIT_POS set
  - Johnson: all zeros
  - The seed tracks the current mode input.
- Priority per rising edge is rst > load > en > hold.
- rst=1:
  - q <= seed(mode)
  - wrap <= 0, illegal <= 0
  - Applies mid-sequence too, including when load or en is asserted.
- load=1:
  - q <= load_val verbatim, with no legality check on this edge.
  - wrap <= 0, illegal <= 0
- en=1 with q legal for the current mode:
  - ring, dir=0: q <= {q[W-2:0], q[W-1]}
  - ring, dir=1: q <= {q[0], q[W-1:1]}
  - Johnson, dir=0: q <= {q[W-2:0], ~q[W-1]}
  - Johnson, dir=1: q <= {~q[0], q[W-1:1]}
  - wrap <= 1 if the next q equals the seed, else 0.
  - illegal <= 0
- en=1 with q illegal for the current mode:
  - q <= seed(mode)
  - illegal <= 1, wrap <= 0
- en=0 (no rst, no load):
  - q holds.
  - wrap <= 0, illegal <= 0
- Legality rules:
  - Ring: popcount(q) == 1. All-zero is illegal.
  - Johnson: popcount(q[W-1:1] ^ q[W-2:0]) <= 1. This gives exactly 2*WIDTH legal states.
- Changing mode or dir mid-sequence:
  - Takes effect on the next enabled edge.
  - The current q is legality-checked against the new mode and corrected if needed.
  - dir changes never cause correction by themselves.
- Period:
  - ring: WIDTH enabled shifts between wrap pulses
  - Johnson: 2*WIDTH enabled shifts between wrap pulses
- wrap and illegal are never both 1.
- Both flags are single-cycle unless en stays high, e.g. a WIDTH=2 ring wraps every other cycle.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Ring reset and count left (WIDTH=4, INIT_POS=0, mode=0, dir=0):
  - Stimulus: rst=1 for 2 cycles, then en=1.
  - Response: q=0001 after reset with wrap=0 and illegal=0; then 0010, 0100, 1000, 0001; wrap=1 only on the return to 0001.
- Ring, dir=1:
  - Response: q=0001, 1000, 0100, 0010, 0001, with wrap=1 on the final 0001.
  - Toggling dir mid-run reverses the sequence from the current q with no illegal pulse.
- Johnson, dir=0 from reset:
  - Response: q=0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000.
  - wrap=1 exactly once per 8 enabled edges.
- Illegal correction:
  - Ring: load_val=0110 with load=1, then en=1. Response: q=0110, then q=0001 with illegal=1 for one cycle and wrap=0.
  - Johnson: load_val=0010, then en=1. Response: q=0000 with illegal=1.
- Priority and hold:
  - en=0: q holds for 5 cycles with both flags 0.
  - load=1 and en=1 together: q=load_val, no shift.
  - rst=1 with load=1 at q=0100: q=0001.
- Mode switch and parameters:
  - In ring mode at q=0100, set mode=1 with en=1. 0100 is illegal in Johnson, so q=0000 with illegal=1.
  - Repeat scenarios 1 and 3 with WIDTH=8, INIT_POS=3: ring seed 00001000, period 8; Johnson period 16.
